// File: rtl/mode4_ctrl.sv
// Mode-4 (sum-of-exponentials) sequencer: walks the exp buffer and steps the 4-input adder tree.
// Optional busy-cycle counter on perf_cycles, built only when MODE4_CTRL_PERF_EN is defined.
module mode4_ctrl #(
  parameter int ADDRW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ADDRW:0]   num_groups,
  input  logic             hold,
  output logic             rd_en,
  output logic [ADDRW-1:0] rd_addr,
  output logic             mode4_run,
  output logic             mode4_stage2_run,
  output logic             mode4_stage1_run,
  output logic             mode4_stage0_run,
  output logic             acc_clear,
  output logic             busy,
  output logic             done,
  output logic [15:0]      perf_cycles
);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDRW:0] MAX_N = {1'b1, {ADDRW{1'b0}}};

  state_t         state;
  state_t         state_next;
  logic [ADDRW:0] n;
  logic [ADDRW:0] addr;
  logic [1:0]     drain_cnt;
  logic           v1;
  logic           v2;
  logic           v3;
  logic           issue_last;
  logic           accept;

  assign accept     = (state == IDLE) && start;
  assign issue_last = ((addr + (ADDRW+1)'(1)) == n);

  assign rd_en            = (state == ISSUE) && !hold;
  assign rd_addr          = addr[ADDRW-1:0];
  assign acc_clear        = (state == CLEAR);
  assign busy             = (state != IDLE);
  assign mode4_run        = busy;
  assign done             = (state == DONE);
  assign mode4_stage2_run = v1 && !hold;
  assign mode4_stage1_run = v2 && !hold;
  assign mode4_stage0_run = v3 && !hold;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // CLEAR and DONE always advance; only ISSUE and DRAIN are stalled by hold.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = (n == '0) ? DONE : ISSUE;
      ISSUE:   if (!hold && issue_last) state_next = DRAIN;
      DRAIN:   if (!hold && drain_cnt == 2'd2) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n         <= '0;
      addr      <= '0;
      drain_cnt <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
    end else begin
      if (accept) n <= (num_groups > MAX_N) ? MAX_N : num_groups;
      if (state == CLEAR)  addr <= '0;
      else if (rd_en)      addr <= addr + (ADDRW+1)'(1);
      if (state != DRAIN)  drain_cnt <= '0;
      else if (!hold)      drain_cnt <= drain_cnt + 2'd1;
      // The valid pipe freezes with the tree so stage enables line up with held data.
      if (!hold) begin
        v1 <= rd_en;
        v2 <= v1;
        v3 <= v2;
      end
    end
  end

`ifdef MODE4_CTRL_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset)                             perf_q <= '0;
    else if (accept)                       perf_q <= '0;
    else if (busy && perf_q != 16'hFFFF)   perf_q <= perf_q + 16'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_mode4_ctrl.sv
// Self-checking bench for mode4_ctrl: directed and random passes checked against a step-schedule model.
module tb_mode4_ctrl;

  localparam int ADDRW = 4;
  localparam int MAXN  = 1 << ADDRW;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [ADDRW:0]   num_groups;
  logic             hold;
  logic             rd_en;
  logic [ADDRW-1:0] rd_addr;
  logic             mode4_run;
  logic             mode4_stage2_run;
  logic             mode4_stage1_run;
  logic             mode4_stage0_run;
  logic             acc_clear;
  logic             busy;
  logic             done;
  logic [15:0]      perf_cycles;

  int checks = 0;
  int errors = 0;

  mode4_ctrl #(.ADDRW(ADDRW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_groups(num_groups), .hold(hold),
    .rd_en(rd_en), .rd_addr(rd_addr), .mode4_run(mode4_run),
    .mode4_stage2_run(mode4_stage2_run), .mode4_stage1_run(mode4_stage1_run),
    .mode4_stage0_run(mode4_stage0_run), .acc_clear(acc_clear), .busy(busy),
    .done(done), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  // Address is only meaningful while rd_en is high, so it is masked otherwise.
  function automatic logic [11:0] observe();
    logic [ADDRW-1:0] a;
    a = rd_en ? rd_addr : '0;
    return {rd_en, a, mode4_stage2_run, mode4_stage1_run, mode4_stage0_run,
            acc_clear, busy, mode4_run, done};
  endfunction

  task automatic test_reset();
    logic [11:0] obs;
    reset = 1'b1; start = 1'b0; hold = 1'b0; num_groups = '0;
    for (int cy = 0; cy < 4; cy++) begin
      @(posedge clk); #1;
      if (cy == 3) reset = 1'b0;
      @(negedge clk);
      obs = observe();
      checks++;
      if (obs !== 12'd0 || perf_cycles !== 16'd0) begin
        errors++;
        $display("[TB] FAIL reset cycle %0d: got %b perf %0d, expected all zero", cy, obs, perf_cycles);
      end
    end
  endtask

  // A pass is N issue steps plus 3 drain steps, each consuming one non-held
  // cycle from cycle 2 on; done lands in the cycle after the last step.
  task automatic test_pass(input int ng, input int hold_pct, input int hold_a,
                           input int hold_b, input int extra_start, input string name);
    int          n, steps, c, last, done_cycle, j;
    int          step_of[200];
    bit          h[200];
    logic [11:0] obs, exp_v;
    logic [ADDRW-1:0] ea;
    logic        er, s2, s1, s0, b;
    logic [15:0] exp_perf;
    n = (ng > MAXN) ? MAXN : ng;
    for (int i = 0; i < 200; i++) begin
      h[i] = ($urandom_range(99) < hold_pct) || (i == hold_a) || (i == hold_b);
      step_of[i] = -1;
    end
    h[0] = 1'b0;
    steps = 0; c = 2; last = 1;
    while (steps < ((n == 0) ? 0 : n + 3) && c < 190) begin
      if (!h[c]) begin
        step_of[c] = steps;
        steps++;
        last = c;
      end
      c++;
    end
    done_cycle = (n == 0) ? 2 : last + 1;
    h[done_cycle + 1] = 1'b0;
`ifdef MODE4_CTRL_PERF_EN
    exp_perf = 16'(done_cycle);
`else
    exp_perf = 16'd0;
`endif
    for (int cy = 0; cy <= done_cycle + 1; cy++) begin
      @(posedge clk); #1;
      start = (cy == 0) || (cy == extra_start);
      num_groups = (cy == 0) ? (ADDRW+1)'(ng) : (ADDRW+1)'($urandom);
      hold = h[cy];
      @(negedge clk);
      j  = step_of[cy];
      er = (j >= 0) && (j < n);
      ea = er ? ADDRW'(j) : '0;
      s2 = (j >= 1) && (j <= n);
      s1 = (j >= 2) && (j <= n + 1);
      s0 = (j >= 3) && (j <= n + 2);
      b  = (cy >= 1) && (cy <= done_cycle);
      exp_v = {er, ea, s2, s1, s0, (cy == 1), b, b, (cy == done_cycle)};
      obs = observe();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cy, obs, exp_v);
      end
      if (cy == done_cycle + 1) begin
        checks++;
        if (perf_cycles !== exp_perf) begin
          errors++;
          $display("[TB] FAIL %s perf_cycles: got %0d expected %0d", name, perf_cycles, exp_perf);
        end
      end
    end
    start = 1'b0; hold = 1'b0;
  endtask

  task automatic test_reset_midpass();
    logic [11:0] obs;
    for (int cy = 0; cy <= 14; cy++) begin
      @(posedge clk); #1;
      start = (cy == 0) || (cy == 6);
      num_groups = (cy == 0) ? (ADDRW+1)'(4) : (cy == 6) ? (ADDRW+1)'(1) : (ADDRW+1)'($urandom);
      reset = (cy == 4);
      hold = 1'b0;
      @(negedge clk);
      obs = observe();
      checks++;
      if (done !== (cy == 12)) begin
        errors++;
        $display("[TB] FAIL reset_midpass done cycle %0d: got %b expected %b", cy, done, (cy == 12));
      end
      if (cy == 5) begin
        checks++;
        if (obs !== 12'd0 || perf_cycles !== 16'd0) begin
          errors++;
          $display("[TB] FAIL reset_midpass outputs cycle 5: got %b perf %0d expected zero", obs, perf_cycles);
        end
      end
      if (cy == 7 || cy == 8) begin
        checks++;
        if (acc_clear !== (cy == 7) || rd_en !== (cy == 8)) begin
          errors++;
          $display("[TB] FAIL reset_midpass restart cycle %0d: got clear %b rd_en %b", cy, acc_clear, rd_en);
        end
      end
    end
    start = 1'b0; reset = 1'b0;
  endtask

  // start held high: with N=2 a new pass is accepted every N+6 = 8 cycles.
  task automatic test_back_to_back();
    logic [2:0] obs, exp_v;
    logic       b;
    for (int cy = 0; cy <= 17; cy++) begin
      @(posedge clk); #1;
      start = (cy <= 15);
      num_groups = (ADDRW+1)'(2);
      hold = 1'b0;
      @(negedge clk);
      b = (cy >= 1 && cy <= 7) || (cy >= 9 && cy <= 15);
      exp_v = {(cy == 1 || cy == 9), b, (cy == 7 || cy == 15)};
      obs = {acc_clear, busy, done};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", cy, obs, exp_v);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; num_groups = '0;
    test_reset();
    test_pass(1, 0, -1, -1, -1, "n1");
    test_pass(4, 0, -1, -1, -1, "n4");
    test_pass(0, 0, -1, -1, -1, "n0");
    test_pass(4, 0, 3, 7, -1, "n4_hold");
    test_pass(4, 0, -1, -1, 3, "start_ignored");
    test_reset_midpass();
    test_back_to_back();
    test_pass(MAXN, 0, -1, -1, -1, "full");
    test_pass(25, 0, -1, -1, -1, "clamp");
    for (int r = 0; r < 10; r++) begin
      test_pass(int'($urandom_range(0, 2 * MAXN - 1)), 30, -1, -1,
                int'($urandom_range(1, 2)), "random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode4_ctrl.md
# mode4_ctrl

Sequencer for the mode-4 (sum-of-exponentials) phase of the softmax datapath. It sits directly upstream of the mode-4 four-input adder tree and reads 4-wide groups of exponentials from the exp buffer. It drives the tree's per-stage run enables and accumulator clear, and pulses `done` when the tree's output register holds the final sum. All pipeline fill, drain and stall bookkeeping lives here; the tree itself stays free of control logic.

## Interface
- `ADDRW`, default 8: exp-buffer group address width; maximum group count is 2^ADDRW.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request to begin one mode-4 pass; sampled only in IDLE.
- `num_groups` in ADDRW+1: number of 4-element groups to sum; latched on accepted `start`.
- `hold` in 1: stall; freezes the sequencer and the in-flight pipeline.
- `rd_en` out 1: exp-buffer read strobe. The buffer has 1-cycle latency, and its output holds while `rd_en` is low.
- `rd_addr` out ADDRW: group address; valid when `rd_en` is high.
- `mode4_run` out 1: phase active; equals `busy`.
- `mode4_stage2_run` out 1: enables the tree's first-level registers.
- `mode4_stage1_run` out 1: enables the tree's second-level register.
- `mode4_stage0_run` out 1: enables the tree's accumulator register.
- `acc_clear` out 1: one-cycle clear. The top level ORs it into the tree's reset.
- `busy` out 1: high from CLEAR through DONE inclusive.
- `done` out 1: one-cycle pulse; the tree output is final in this cycle.
- `perf_cycles` out 16: busy-cycle counter (see Configuration).

## Operation
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE, `start`=1:
  - Latch `num_groups` into N.
  - Go to CLEAR.
  - `start` is ignored in every other state.
- CLEAR (one cycle): `acc_clear`=1.
  - N>0: go to ISSUE.
  - N=0: go to DONE.
- ISSUE, `hold`=0:
  - `rd_en`=1; `rd_addr` steps 0,1,…,N-1 in successive cycles.
  - After address N-1 is issued, go to DRAIN.
- DRAIN:
  - Wait 3 non-held cycles, until the valid pipe is empty.
  - Then go to DONE.
- DONE (one cycle): `done`=1, then go to IDLE.
- Valid pipe v1..v3:
  - v1 = `rd_en` delayed 1 cycle; v2 = v1 delayed; v3 = v2 delayed.
  - `mode4_stage2_run` = v1 & ~`hold`.
  - `mode4_stage1_run` = v2 & ~`hold`.
  - `mode4_stage0_run` = v3 & ~`hold`.
- `hold`=1:
  - `rd_en`=0 and all stage runs are 0.
  - The FSM, address counter, DRAIN counter and v1..v3 all keep their values.
  - `acc_clear` and `done` are not delayed by `hold`; CLEAR and DONE complete regardless.
- Address counter width: ADDRW+1 internally, so N=2^ADDRW issues addresses 0..2^ADDRW-1 without early wrap. `rd_addr` carries the low ADDRW bits.
- `num_groups` > 2^ADDRW: clamp to 2^ADDRW.
- Reset, including mid-pass:
  - State returns to IDLE.
  - v1..v3, counters and all outputs go to 0.
  - No `done` pulse for the aborted pass.

## Timing
- `start` accepted in cycle 0, no `hold` (cycle numbering below uses this).
- Cycle 1: CLEAR, `acc_clear`=1. The tree accumulator reads 0 from cycle 2.
- Cycles 2..N+1: `rd_en`=1, with `rd_addr` = cycle-2.
- Cycles 3..N+2: `mode4_stage2_run`.
- Cycles 4..N+3: `mode4_stage1_run`.
- Cycles 5..N+4: `mode4_stage0_run`.
- DRAIN occupies cycles N+2..N+4; `done` is in cycle N+5.
- Total latency, `start` to `done`: N+5 cycles. Throughput is one group per cycle.
- N=0: `done` in cycle 2; the tree output reads 0.
- Each cycle with `hold`=1 during ISSUE or DRAIN delays everything that follows by 1 cycle.
- Earliest next accepted `start`: cycle N+6.
- Reset values:
  - Outputs `rd_en`, `rd_addr`, all stage runs, `acc_clear`, `busy`, `mode4_run`, `done` and `perf_cycles` are all 0.
  - Internally, state is IDLE.

## Configuration
- Macro: `MODE4_CTRL_PERF_EN`.
- Defined:
  - `perf_cycles` clears on accepted `start`.
  - It increments each cycle `busy`=1, including held cycles.
  - It saturates at 16'hFFFF and holds its value after `done`.
- Undefined: `perf_cycles` is tied to 0, and no counter logic is built.

## Test plan
- N=1, buffer group 0 = {1.0,2.0,3.0,4.0}, no hold:
  - `rd_en` in cycle 2 only.
  - Stage runs in cycles 3/4/5.
  - `done` in cycle 6, tree output 10.0.
- N=4, every element 1.0:
  - `rd_addr` 0..3 in cycles 2..5.
  - `done` in cycle 9, output 16.0.
  - With PERF_EN, `perf_cycles`=9.
- N=0: `acc_clear` in cycle 1, `done` in cycle 2, no `rd_en`, no stage runs, output 0.
- N=4 with `hold`=1 in cycles 3 and 7:
  - No `rd_en` and no stage runs in held cycles.
  - `done` in cycle 11, output 16.0.
- `start` pulsed in cycle 3 of an N=4 pass: ignored; exactly one `done`, in cycle 9.
- `reset` in cycle 4 of an N=4 pass:
  - All outputs 0 from cycle 5; no `done`.
  - A new `start` in cycle 6 with N=1 gives `done` in cycle 12.
